// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
//
// Boot-time program loader. After a single-cycle i_start pulse it takes a
// little-endian 16-bit word count N from a valid/ready byte stream, then N
// little-endian 32-bit words, and writes each word to instruction memory at
// BASE_ADDR + 4*k. The attached core is held in reset (o_core_rst_n = 0) from
// the start of a load until the load completes successfully.
//
// Optional feature: define LOADER_CHECKSUM_EN to expect one trailing checksum
// byte (8-bit sum of all payload bytes, modulo 256). A match finishes the
// load; a mismatch aborts it. Without the macro no checksum logic is built and
// the CHK state is never entered.
//
// Parameters
//   MAX_WORDS     largest accepted program length in 32-bit words
//   BASE_ADDR     instruction-memory byte address of word 0
//
// Ports
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset (aborts any load)
//   i_start       single-cycle load request (honoured in IDLE/DONE/ERROR)
//   i_byte_valid  byte-stream valid
//   i_byte_data   byte-stream data
//   o_byte_ready  byte-stream ready (LEN0, LEN1, DATA, CHK)
//   o_imem_we     one-cycle instruction-memory write strobe
//   o_imem_addr   instruction-memory byte address (held between writes)
//   o_imem_data   instruction-memory write word (held between writes)
//   o_core_rst_n  core reset hold; 1 only after a successful load
//   o_busy        load in progress
//   o_done        load completed successfully
//   o_error       load aborted (bad length or checksum)
//   o_word_count  words written in the current load
// -----------------------------------------------------------------------------
module prog_loader #(
    parameter int unsigned MAX_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte_data,
    output logic        o_byte_ready,
    output logic        o_imem_we,
    output logic [31:0] o_imem_addr,
    output logic [31:0] o_imem_data,
    output logic        o_core_rst_n,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error,
    output logic [15:0] o_word_count
);

    typedef enum logic [2:0] {
        IDLE,
        LEN0,
        LEN1,
        DATA,
        WRITE,
        CHK,
        DONE,
        ERROR
    } state_t;

    state_t      state;
    logic [15:0] len;        // program length N in words
    logic [23:0] word_buf;   // first three bytes of the word being assembled
    logic [1:0]  byte_idx;   // byte position within the current word

`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  sum;        // running modulo-256 sum of payload bytes
`endif

    logic        xfer;
    logic [15:0] len_next;
    logic        len_bad;

    assign xfer     = i_byte_valid & o_byte_ready;
    // Length as it will be once the LEN1 byte lands; validated in that cycle
    // so the state after the LEN1 transfer is already DATA or ERROR.
    assign len_next = {i_byte_data, len[7:0]};
    assign len_bad  = (len_next == 16'd0) || (32'(len_next) > MAX_WORDS);

    // Single FSM process. Outputs are registers updated together with the
    // state so each output is a clean flop, never a decode of the state.
    // NOTE: every assignment here is non-blocking so all registers update
    // from the same pre-edge values; blocking would make the result depend
    // on statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            len          <= '0;
            word_buf     <= '0;
            byte_idx     <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum          <= '0;
`endif
            o_byte_ready <= 1'b0;
            o_imem_we    <= 1'b0;
            o_imem_addr  <= '0;
            o_imem_data  <= '0;
            o_core_rst_n <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_error      <= 1'b0;
            o_word_count <= '0;
        end else begin
            // NOTE: default-low strobe ahead of the case statement makes the
            // write pulse last exactly one cycle without repeating the
            // assignment in every branch.
            o_imem_we <= 1'b0;

            case (state)
                IDLE, DONE, ERROR: begin
                    if (i_start) begin
                        state        <= LEN0;
                        byte_idx     <= '0;
`ifdef LOADER_CHECKSUM_EN
                        sum          <= '0;
`endif
                        o_byte_ready <= 1'b1;
                        o_busy       <= 1'b1;
                        o_done       <= 1'b0;
                        o_error      <= 1'b0;
                        o_core_rst_n <= 1'b0;
                        o_word_count <= '0;
                    end
                end

                LEN0: begin
                    if (xfer) begin
                        len[7:0] <= i_byte_data;
                        state    <= LEN1;
                    end
                end

                LEN1: begin
                    if (xfer) begin
                        len[15:8] <= i_byte_data;
                        if (len_bad) begin
                            state        <= ERROR;
                            o_byte_ready <= 1'b0;
                            o_busy       <= 1'b0;
                            o_error      <= 1'b1;
                        end else begin
                            state <= DATA;
                        end
                    end
                end

                DATA: begin
                    if (xfer) begin
                        // Shift right so the first byte ends up in [7:0].
                        word_buf <= {i_byte_data, word_buf[23:8]};
                        byte_idx <= byte_idx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        sum      <= sum + i_byte_data;
`endif
                        if (byte_idx == 2'd3) begin
                            state        <= WRITE;
                            o_byte_ready <= 1'b0;
                            o_imem_we    <= 1'b1;
                            // Address arithmetic wraps naturally at 2^32.
                            o_imem_addr  <= BASE_ADDR + {14'd0, o_word_count, 2'b00};
                            o_imem_data  <= {i_byte_data, word_buf};
                            o_word_count <= o_word_count + 16'd1;
                        end
                    end
                end

                WRITE: begin
                    // o_word_count already holds the post-write value here.
                    if (o_word_count < len) begin
                        state        <= DATA;
                        o_byte_ready <= 1'b1;
                    end else begin
`ifdef LOADER_CHECKSUM_EN
                        state        <= CHK;
                        o_byte_ready <= 1'b1;
`else
                        state        <= DONE;
                        o_busy       <= 1'b0;
                        o_done       <= 1'b1;
                        o_core_rst_n <= 1'b1;
`endif
                    end
                end

`ifdef LOADER_CHECKSUM_EN
                CHK: begin
                    if (xfer) begin
                        o_byte_ready <= 1'b0;
                        o_busy       <= 1'b0;
                        if (i_byte_data == sum) begin
                            state        <= DONE;
                            o_done       <= 1'b1;
                            o_core_rst_n <= 1'b1;
                        end else begin
                            state   <= ERROR;
                            o_error <= 1'b1;
                        end
                    end
                end
`endif

                default: begin
                    state        <= IDLE;
                    o_byte_ready <= 1'b0;
                    o_busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_prog_loader
//
// Self-checking bench for prog_loader. A table of length vectors and a set of
// random programs are driven through the byte stream (optionally with random
// valid gaps); a reference model derives the expected memory image directly
// from the byte stream, and a write monitor collects every o_imem_we pulse.
// Hand-written sequences cover the literal example stream, i_start during a
// load, reset mid-load and (with LOADER_CHECKSUM_EN) checksum match/mismatch.
// -----------------------------------------------------------------------------
module tb_prog_loader;

    localparam int unsigned MAX_WORDS = 1024;
    localparam logic [31:0] BASE_ADDR = 32'h0000_0000;

    typedef logic [7:0] bq_t[$];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [7:0] lo;
        logic [7:0] hi;
        int         max_gap;
        bit         exp_err;
    } vec_t;

    logic        clk          = 1'b0;
    logic        rst_n        = 1'b0;
    logic        i_start      = 1'b0;
    logic        i_byte_valid = 1'b0;
    logic [7:0]  i_byte_data  = 8'h00;
    logic        o_byte_ready;
    logic        o_imem_we;
    logic [31:0] o_imem_addr;
    logic [31:0] o_imem_data;
    logic        o_core_rst_n;
    logic        o_busy;
    logic        o_done;
    logic        o_error;
    logic [15:0] o_word_count;

    int checks   = 0;
    int failures = 0;

    wr_t got_q[$];

    prog_loader #(
        .MAX_WORDS (MAX_WORDS),
        .BASE_ADDR (BASE_ADDR)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (i_start),
        .i_byte_valid (i_byte_valid),
        .i_byte_data  (i_byte_data),
        .o_byte_ready (o_byte_ready),
        .o_imem_we    (o_imem_we),
        .o_imem_addr  (o_imem_addr),
        .o_imem_data  (o_imem_data),
        .o_core_rst_n (o_core_rst_n),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_error      (o_error),
        .o_word_count (o_word_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h expected=0x%08h @%0t", name, got, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%b expected=%b @%0t", name, got, exp, $time);
        end
    endtask

    // Write monitor: records every strobe, checks it is a single-cycle pulse
    // and that address/data stay put between strobes.
    logic        prev_we   = 1'b0;
    logic        prev_rst  = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] prev_data = '0;

    always @(negedge clk) begin
        if (o_imem_we) begin
            got_q.push_back('{addr: o_imem_addr, data: o_imem_data});
            check_bit("we_one_cycle", prev_we, 1'b0);
        end else if (rst_n && prev_rst) begin
            check("addr_hold", o_imem_addr, prev_addr);
            check("data_hold", o_imem_data, prev_data);
        end
        prev_we   = o_imem_we;
        prev_rst  = rst_n;
        prev_addr = o_imem_addr;
        prev_data = o_imem_data;
    end

    initial begin
        #800_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [7:0] payload_sum(input bq_t s);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 2; i < s.size(); i++) acc = acc + s[i];
        return acc;
    endfunction

    // Length bytes, then 4*N random payload bytes (plus checksum when built
    // with the checksum feature) if N is acceptable.
    function automatic bq_t make_stream(input logic [7:0] lo, input logic [7:0] hi);
        bq_t         s;
        logic [15:0] n;
        n = {hi, lo};
        s.push_back(lo);
        s.push_back(hi);
        if (n != 16'd0 && 32'(n) <= MAX_WORDS) begin
            for (int i = 0; i < 4 * int'(n); i++) s.push_back(8'($urandom));
`ifdef LOADER_CHECKSUM_EN
            s.push_back(payload_sum(s));
`endif
        end
        return s;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bytes(input bq_t bytes, input int max_gap);
        foreach (bytes[i]) begin
            int budget;
            bit taken;
            budget = 0;
            taken  = 1'b0;
            repeat ($urandom_range(max_gap, 0)) begin
                i_byte_valid = 1'b0;
                step();
            end
            i_byte_valid = 1'b1;
            i_byte_data  = bytes[i];
            while (!taken && budget < 50) begin
                taken = o_byte_ready;
                step();
                budget++;
            end
            if (!taken) begin
                check_bit("byte_accept_timeout", 1'b0, 1'b1);
                i_byte_valid = 1'b0;
                return;
            end
        end
        i_byte_valid = 1'b0;
    endtask

    task automatic do_start();
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        check_bit("start_busy",     o_busy,       1'b1);
        check_bit("start_ready",    o_byte_ready, 1'b1);
        check_bit("start_core_rst", o_core_rst_n, 1'b0);
        check_bit("start_done",     o_done,       1'b0);
        check_bit("start_error",    o_error,      1'b0);
        check("start_count", 32'(o_word_count), 32'd0);
    endtask

    task automatic wait_end();
        int budget;
        budget = 0;
        while (!(o_done || o_error) && budget < 200) begin
            step();
            budget++;
        end
        check_bit("end_reached", (budget < 200), 1'b1);
    endtask

    // Full load of one stream, compared against the memory image the model
    // derives from the stream itself.
    task automatic run_load(input bq_t s, input int max_gap, input bit exp_err);
        logic [15:0] n;
        bit          len_bad;
        wr_t         exp_q[$];
        bq_t         len_only;
        n       = {s[1], s[0]};
        len_bad = (n == 16'd0) || (32'(n) > MAX_WORDS);
        if (!len_bad) begin
            for (int k = 0; k < int'(n); k++) begin
                exp_q.push_back('{addr: BASE_ADDR + 32'(4 * k),
                                  data: {s[2+4*k+3], s[2+4*k+2], s[2+4*k+1], s[2+4*k]}});
            end
        end
        got_q.delete();
        do_start();
        if (len_bad) begin
            len_only = '{s[0], s[1]};
            send_bytes(len_only, max_gap);
            check_bit("len_err_next_cycle", o_error, 1'b1);
            check_bit("len_err_core_rst",   o_core_rst_n, 1'b0);
        end else begin
            send_bytes(s, max_gap);
        end
        wait_end();
        repeat (2) step();
        check_bit("end_error",    o_error,      exp_err);
        check_bit("end_done",     o_done,       !exp_err);
        check_bit("end_core_rst", o_core_rst_n, !exp_err);
        check_bit("end_busy",     o_busy,       1'b0);
        check_bit("end_ready",    o_byte_ready, 1'b0);
        check("end_word_count", 32'(o_word_count), len_bad ? 32'd0 : 32'(n));
        check("write_count", 32'(got_q.size()), 32'(exp_q.size()));
        foreach (exp_q[k]) begin
            if (k < got_q.size()) begin
                check("write_addr", got_q[k].addr, exp_q[k].addr);
                check("write_data", got_q[k].data, exp_q[k].data);
            end
        end
    endtask

    initial begin
        vec_t vecs[7];
        bq_t  s39;
        bq_t  s;

        vecs[0] = '{lo: 8'h00, hi: 8'h00, max_gap: 0, exp_err: 1'b1};  // N = 0
        vecs[1] = '{lo: 8'h01, hi: 8'h04, max_gap: 0, exp_err: 1'b1};  // N = 1025
        vecs[2] = '{lo: 8'hFF, hi: 8'hFF, max_gap: 2, exp_err: 1'b1};  // N = 65535
        vecs[3] = '{lo: 8'h01, hi: 8'h00, max_gap: 0, exp_err: 1'b0};  // N = 1
        vecs[4] = '{lo: 8'h03, hi: 8'h00, max_gap: 2, exp_err: 1'b0};  // N = 3
        vecs[5] = '{lo: 8'h00, hi: 8'h04, max_gap: 0, exp_err: 1'b0};  // N = MAX_WORDS
        vecs[6] = '{lo: 8'h07, hi: 8'h00, max_gap: 1, exp_err: 1'b0};  // N = 7

        s39 = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
`ifdef LOADER_CHECKSUM_EN
        s39.push_back(payload_sum(s39));
`endif

        // Reset state while rst_n is held low.
        repeat (3) @(posedge clk);
        #1;
        check_bit("rst_ready",    o_byte_ready, 1'b0);
        check_bit("rst_we",       o_imem_we,    1'b0);
        check("rst_addr", o_imem_addr, 32'd0);
        check("rst_data", o_imem_data, 32'd0);
        check_bit("rst_core_rst", o_core_rst_n, 1'b0);
        check_bit("rst_busy",     o_busy,       1'b0);
        check_bit("rst_done",     o_done,       1'b0);
        check_bit("rst_error",    o_error,      1'b0);
        check("rst_count", 32'(o_word_count), 32'd0);
        rst_n = 1'b1;
        step();

        // Literal example stream, back-to-back bytes: the 5th byte is held
        // valid through the WRITE cycle of word 0.
        run_load(s39, 0, 1'b0);
        check("ex_write_count", 32'(got_q.size()), 32'd2);
        if (got_q.size() == 2) begin
            check("ex_addr0", got_q[0].addr, 32'h0000_0000);
            check("ex_data0", got_q[0].data, 32'h1234_5678);
            check("ex_addr1", got_q[1].addr, 32'h0000_0004);
            check("ex_data1", got_q[1].data, 32'hDEAD_BEEF);
        end
        check("ex_word_count", 32'(o_word_count), 32'd2);

        // Same stream with random valid gaps.
        run_load(s39, 3, 1'b0);
        if (got_q.size() == 2) begin
            check("gap_data0", got_q[0].data, 32'h1234_5678);
            check("gap_data1", got_q[1].data, 32'hDEAD_BEEF);
        end

        // Table of length vectors.
        for (int v = 0; v < 7; v++) begin
            s = make_stream(vecs[v].lo, vecs[v].hi);
            run_load(s, vecs[v].max_gap, vecs[v].exp_err);
        end

        // Random programs.
        for (int r = 0; r < 6; r++) begin
            logic [15:0] n;
            n = 16'($urandom_range(12, 1));
            s = make_stream(n[7:0], n[15:8]);
            run_load(s, int'($urandom_range(3, 0)), 1'b0);
        end

        // i_start in the middle of DATA is ignored.
        got_q.delete();
        do_start();
        s = '{8'h01, 8'h00, 8'hAA, 8'hBB};
        send_bytes(s, 0);
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        check_bit("ign_start_busy",  o_busy,       1'b1);
        check_bit("ign_start_ready", o_byte_ready, 1'b1);
        check("ign_start_count", 32'(o_word_count), 32'd0);
        s = '{8'hCC, 8'hDD};
`ifdef LOADER_CHECKSUM_EN
        s.push_back(8'h0E);
`endif
        send_bytes(s, 0);
        wait_end();
        check_bit("ign_start_done", o_done, 1'b1);
        check("ign_start_writes", 32'(got_q.size()), 32'd1);
        if (got_q.size() == 1) check("ign_start_data", got_q[0].data, 32'hDDCC_BBAA);

`ifdef LOADER_CHECKSUM_EN
        // Checksum match and mismatch.
        s = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h14};
        run_load(s, 0, 1'b0);
        s = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h15};
        run_load(s, 1, 1'b1);
`endif

        // Reset after the 2nd DATA word of a 4-word load.
        got_q.delete();
        do_start();
        s = '{8'h04, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        send_bytes(s, 0);
        step();
        check("mid_word_count", 32'(o_word_count), 32'd2);
        rst_n = 1'b0;
        #1;
        check_bit("mid_rst_ready",    o_byte_ready, 1'b0);
        check_bit("mid_rst_we",       o_imem_we,    1'b0);
        check("mid_rst_addr", o_imem_addr, 32'd0);
        check("mid_rst_data", o_imem_data, 32'd0);
        check_bit("mid_rst_core_rst", o_core_rst_n, 1'b0);
        check_bit("mid_rst_busy",     o_busy,       1'b0);
        check_bit("mid_rst_done",     o_done,       1'b0);
        check_bit("mid_rst_error",    o_error,      1'b0);
        check("mid_rst_count", 32'(o_word_count), 32'd0);
        step();
        rst_n = 1'b1;
        repeat (2) step();
        check_bit("post_rst_idle_busy", o_busy, 1'b0);
        run_load(s39, 0, 1'b0);
        if (got_q.size() == 2) begin
            check("post_rst_addr0", got_q[0].addr, BASE_ADDR);
            check("post_rst_data0", got_q[0].data, 32'h1234_5678);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
